// File: rtl/depacketizer_if.sv
// Camera packet stream bus: word input with its valid qualifier, plus the
// decoded pixel, framing, control/status and error outputs.
interface depacketizer_if #(
  parameter int LEN_W = 11
);
  logic [8:0]       in_word;
  logic             in_valid;
  logic [7:0]       pix_data;
  logic             pix_valid;
  logic             line_start;
  logic             line_end;
  logic [LEN_W-1:0] line_len;
  logic [9:0]       line_count;
  logic             frame_start;
  logic [7:0]       status_byte;
  logic             status_valid;
  logic [7:0]       ctrl_data;
  logic             ctrl_valid;
  logic             sync_locked;
  logic             err_sync;
  logic             err_len;

  // Producer of the packet stream / consumer of the decoded outputs
  modport master (
    output in_word, in_valid,
    input  pix_data, pix_valid, line_start, line_end, line_len, line_count,
           frame_start, status_byte, status_valid, ctrl_data, ctrl_valid,
           sync_locked, err_sync, err_len
  );

  // The depacketizer itself
  modport slave (
    input  in_word, in_valid,
    output pix_data, pix_valid, line_start, line_end, line_len, line_count,
           frame_start, status_byte, status_valid, ctrl_data, ctrl_valid,
           sync_locked, err_sync, err_len
  );
endinterface

// File: rtl/depacketizer.sv
// Receive-side packet decoder: hunts for the 12-word sync header, checks the
// repeated type word, then splits the payload into a pixel stream (type 1FF)
// or a status/control stream (type 100). All outputs are registered, so the
// response to a word appears the cycle after it is sampled.
module depacketizer #(
  parameter int TYPE_LEN = 2,
  parameter int MAX_LEN  = 1023,
  parameter int LEN_W    = 11
) (
  input logic          clk,
  input logic          rst,
  depacketizer_if.slave bus
);

  localparam logic [2:0] S_HUNT      = 3'd0;
  localparam logic [2:0] S_HDR       = 3'd1;
  localparam logic [2:0] S_TYPE_WAIT = 3'd2;
  localparam logic [2:0] S_TYPE      = 3'd3;
  localparam logic [2:0] S_DATA      = 3'd4;
  localparam logic [2:0] S_CTRL      = 3'd5;

  localparam logic [8:0]       W_DATA     = 9'h1FF;
  localparam logic [8:0]       W_CTRL     = 9'h100;
  localparam logic [7:0]       TYPE_LEN_C = TYPE_LEN[7:0];
  localparam logic [LEN_W-1:0] MAX_LEN_C  = MAX_LEN[LEN_W-1:0];

  // Expected sync header word at position idx (all carry marker=1)
  function automatic logic [8:0] hdr_word(input logic [3:0] idx);
    case (idx)
      4'd0, 4'd6:  hdr_word = 9'h10A;
      4'd1, 4'd7:  hdr_word = 9'h101;
      4'd2, 4'd8:  hdr_word = 9'h102;
      4'd3, 4'd9:  hdr_word = 9'h103;
      4'd4, 4'd10: hdr_word = 9'h104;
      4'd5:        hdr_word = 9'h105;
      default:     hdr_word = 9'h1CC;
    endcase
  endfunction

  logic [2:0]       state_q, state_d;
  logic [3:0]       hdr_idx_q, hdr_idx_d;
  logic             is_data_q, is_data_d;
  logic [7:0]       type_cnt_q, type_cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [7:0]       pix_data_q, pix_data_d;
  logic             pix_valid_q, pix_valid_d;
  logic             line_start_q, line_start_d;
  logic             line_end_q, line_end_d;
  logic [LEN_W-1:0] line_len_q, line_len_d;
  logic [9:0]       line_count_q, line_count_d;
  logic             frame_start_q, frame_start_d;
  logic [7:0]       status_byte_q, status_byte_d;
  logic             status_valid_q, status_valid_d;
  logic [7:0]       ctrl_data_q, ctrl_data_d;
  logic             ctrl_valid_q, ctrl_valid_d;
  logic             sync_locked_q, sync_locked_d;
  logic             err_sync_q, err_sync_d;
  logic             err_len_q, err_len_d;
  logic             enter_payload;
  logic             enter_data;
  logic [8:0]       w;

  assign w = bus.in_word;

  // Next-state and output decode for one sampled word
  always_comb begin
    state_d        = state_q;
    hdr_idx_d      = hdr_idx_q;
    is_data_d      = is_data_q;
    type_cnt_d     = type_cnt_q;
    len_d          = len_q;
    pix_data_d     = pix_data_q;
    pix_valid_d    = 1'b0;
    line_start_d   = 1'b0;
    line_end_d     = 1'b0;
    line_len_d     = line_len_q;
    line_count_d   = line_count_q;
    frame_start_d  = 1'b0;
    status_byte_d  = status_byte_q;
    status_valid_d = 1'b0;
    ctrl_data_d    = ctrl_data_q;
    ctrl_valid_d   = 1'b0;
    err_sync_d     = 1'b0;
    err_len_d      = 1'b0;
    enter_payload  = 1'b0;
    enter_data     = 1'b0;

    if (bus.in_valid) begin
      case (state_q)
        S_HUNT: begin
          if (w == hdr_word(4'd0)) begin
            state_d   = S_HDR;
            hdr_idx_d = 4'd1;
          end
        end
        S_HDR: begin
          if (w == hdr_word(hdr_idx_q)) begin
            if (hdr_idx_q == 4'd11) state_d = S_TYPE_WAIT;
            else                    hdr_idx_d = hdr_idx_q + 4'd1;
          end else if (w == hdr_word(4'd0)) begin
            // A mismatching word may itself begin a new header
            hdr_idx_d = 4'd1;
          end else begin
            state_d = S_HUNT;
          end
        end
        S_TYPE_WAIT: begin
          if (w == W_DATA || w == W_CTRL) begin
            is_data_d  = (w == W_DATA);
            type_cnt_d = 8'd1;
            if (TYPE_LEN_C == 8'd1) begin
              enter_payload = 1'b1;
              enter_data    = (w == W_DATA);
            end else begin
              state_d = S_TYPE;
            end
          end else if (w[8]) begin
            err_sync_d = 1'b1;
            state_d    = S_HUNT;
          end
        end
        S_TYPE: begin
          if (w == (is_data_q ? W_DATA : W_CTRL)) begin
            type_cnt_d = type_cnt_q + 8'd1;
            if (type_cnt_q + 8'd1 == TYPE_LEN_C) begin
              enter_payload = 1'b1;
              enter_data    = is_data_q;
            end
          end else begin
            err_sync_d = 1'b1;
            state_d    = S_HUNT;
          end
        end
        S_DATA: begin
          if (w[8]) begin
            if (len_q == MAX_LEN_C) begin
              err_len_d = 1'b1;
              state_d   = S_HUNT;
            end else begin
              pix_valid_d  = 1'b1;
              pix_data_d   = w[7:0];
              line_start_d = (len_q == '0);
              len_d        = len_q + 1'b1;
            end
          end else begin
            line_end_d   = 1'b1;
            line_len_d   = len_q;
            line_count_d = line_count_q + 10'd1;
            state_d      = S_HUNT;
          end
        end
        S_CTRL: begin
          if (w[8]) begin
            if (len_q == MAX_LEN_C) begin
              err_len_d = 1'b1;
              state_d   = S_HUNT;
            end else begin
              if (len_q == '0) begin
                status_byte_d  = w[7:0];
                status_valid_d = 1'b1;
              end else begin
                ctrl_data_d  = w[7:0];
                ctrl_valid_d = 1'b1;
              end
              len_d = len_q + 1'b1;
            end
          end else begin
            state_d = S_HUNT;
          end
        end
        default: state_d = S_HUNT;
      endcase

      if (enter_payload) begin
        len_d = '0;
        if (enter_data) begin
          state_d = S_DATA;
        end else begin
          state_d       = S_CTRL;
          frame_start_d = 1'b1;
          line_count_d  = 10'd0;
        end
      end
    end

    sync_locked_d = (state_d == S_TYPE_WAIT) || (state_d == S_TYPE) ||
                    (state_d == S_DATA) || (state_d == S_CTRL);
  end

  // State and output registers; reset discards any packet in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_HUNT;
      hdr_idx_q      <= 4'd0;
      is_data_q      <= 1'b0;
      type_cnt_q     <= 8'd0;
      len_q          <= '0;
      pix_data_q     <= 8'd0;
      pix_valid_q    <= 1'b0;
      line_start_q   <= 1'b0;
      line_end_q     <= 1'b0;
      line_len_q     <= '0;
      line_count_q   <= 10'd0;
      frame_start_q  <= 1'b0;
      status_byte_q  <= 8'd0;
      status_valid_q <= 1'b0;
      ctrl_data_q    <= 8'd0;
      ctrl_valid_q   <= 1'b0;
      sync_locked_q  <= 1'b0;
      err_sync_q     <= 1'b0;
      err_len_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      hdr_idx_q      <= hdr_idx_d;
      is_data_q      <= is_data_d;
      type_cnt_q     <= type_cnt_d;
      len_q          <= len_d;
      pix_data_q     <= pix_data_d;
      pix_valid_q    <= pix_valid_d;
      line_start_q   <= line_start_d;
      line_end_q     <= line_end_d;
      line_len_q     <= line_len_d;
      line_count_q   <= line_count_d;
      frame_start_q  <= frame_start_d;
      status_byte_q  <= status_byte_d;
      status_valid_q <= status_valid_d;
      ctrl_data_q    <= ctrl_data_d;
      ctrl_valid_q   <= ctrl_valid_d;
      sync_locked_q  <= sync_locked_d;
      err_sync_q     <= err_sync_d;
      err_len_q      <= err_len_d;
    end
  end

  assign bus.pix_data     = pix_data_q;
  assign bus.pix_valid    = pix_valid_q;
  assign bus.line_start   = line_start_q;
  assign bus.line_end     = line_end_q;
  assign bus.line_len     = line_len_q;
  assign bus.line_count   = line_count_q;
  assign bus.frame_start  = frame_start_q;
  assign bus.status_byte  = status_byte_q;
  assign bus.status_valid = status_valid_q;
  assign bus.ctrl_data    = ctrl_data_q;
  assign bus.ctrl_valid   = ctrl_valid_q;
  assign bus.sync_locked  = sync_locked_q;
  assign bus.err_sync     = err_sync_q;
  assign bus.err_len      = err_len_q;

endmodule

// File: tb/tb_depacketizer.sv
// Directed bench for depacketizer: header hunting, data and control packets,
// type errors, length overflow, in_valid gaps and mid-packet reset.
module tb_depacketizer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic gap = 1'b0;

  int n_chk = 0;
  int n_bad = 0;

  // Event counters, written only by the monitor below
  int cnt_pix = 0, cnt_ctrl = 0, cnt_lend = 0, cnt_esync = 0, cnt_elen = 0;
  int cnt_fs = 0, cnt_stat = 0;
  logic [7:0] last_pix = 8'd0;
  logic [7:0] last_ctrl = 8'd0;

  int b_pix, b_ctrl, b_lend, b_esync, b_elen, b_fs, b_stat;

  depacketizer_if #(.LEN_W(11)) bus ();

  depacketizer #(.TYPE_LEN(2), .MAX_LEN(1023), .LEN_W(11)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Count output strobes in the middle of each cycle
  always @(negedge clk) begin
    if (bus.pix_valid)    begin cnt_pix   <= cnt_pix + 1; last_pix <= bus.pix_data; end
    if (bus.ctrl_valid)   begin cnt_ctrl  <= cnt_ctrl + 1; last_ctrl <= bus.ctrl_data; end
    if (bus.line_end)     cnt_lend  <= cnt_lend + 1;
    if (bus.err_sync)     cnt_esync <= cnt_esync + 1;
    if (bus.err_len)      cnt_elen  <= cnt_elen + 1;
    if (bus.frame_start)  cnt_fs    <= cnt_fs + 1;
    if (bus.status_valid) cnt_stat  <= cnt_stat + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one word; returns #1 after the sampling edge so registered
  // outputs for this word are visible. With gap set, an idle cycle follows.
  task automatic send(input logic [8:0] wd);
    bus.in_word  = wd;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_word  = 9'h10A;
    if (gap) begin @(posedge clk); #1; end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_hdr;
    logic [8:0] h [12];
    h = '{9'h10A, 9'h101, 9'h102, 9'h103, 9'h104, 9'h105,
          9'h10A, 9'h101, 9'h102, 9'h103, 9'h104, 9'h1CC};
    for (int i = 0; i < 12; i++) send(h[i]);
  endtask

  task automatic snap;
    idle(1);
    b_pix = cnt_pix; b_ctrl = cnt_ctrl; b_lend = cnt_lend; b_esync = cnt_esync;
    b_elen = cnt_elen; b_fs = cnt_fs; b_stat = cnt_stat;
  endtask

  initial begin
    bus.in_word  = 9'h000;
    bus.in_valid = 1'b0;
    idle(3);
    rst = 1'b0;
    idle(1);
    check_val("rst_locked", 32'(bus.sync_locked), 32'd0);
    check_val("rst_pixv",   32'(bus.pix_valid),   32'd0);
    check_val("rst_llen",   32'(bus.line_len),    32'd0);
    check_val("rst_lcnt",   32'(bus.line_count),  32'd0);
    check_val("rst_stat",   32'(bus.status_byte), 32'd0);
    check_val("rst_pixd",   32'(bus.pix_data),    32'd0);

    // Data packet 11,22,33
    snap();
    send_hdr();
    check_val("t1_locked", 32'(bus.sync_locked), 32'd1);
    send(9'h1FF); send(9'h1FF);
    send(9'h111);
    check_val("t1_pv0", 32'(bus.pix_valid), 32'd1);
    check_val("t1_pd0", 32'(bus.pix_data), 32'h11);
    check_val("t1_ls0", 32'(bus.line_start), 32'd1);
    send(9'h122);
    check_val("t1_pd1", 32'(bus.pix_data), 32'h22);
    check_val("t1_ls1", 32'(bus.line_start), 32'd0);
    send(9'h133);
    check_val("t1_pd2", 32'(bus.pix_data), 32'h33);
    send(9'h000);
    check_val("t1_lend", 32'(bus.line_end), 32'd1);
    check_val("t1_llen", 32'(bus.line_len), 32'd3);
    check_val("t1_lcnt", 32'(bus.line_count), 32'd1);
    check_val("t1_unlock", 32'(bus.sync_locked), 32'd0);
    idle(1);
    check_val("t1_npix", 32'(cnt_pix - b_pix), 32'd3);

    // Control packet 5A,A1,A2,00,00
    snap();
    send_hdr();
    send(9'h100); send(9'h100);
    check_val("t2_fs", 32'(bus.frame_start), 32'd1);
    check_val("t2_lcnt", 32'(bus.line_count), 32'd0);
    send(9'h15A);
    check_val("t2_sv", 32'(bus.status_valid), 32'd1);
    check_val("t2_sb", 32'(bus.status_byte), 32'h5A);
    check_val("t2_cv0", 32'(bus.ctrl_valid), 32'd0);
    send(9'h1A1);
    check_val("t2_cv1", 32'(bus.ctrl_valid), 32'd1);
    check_val("t2_cd1", 32'(bus.ctrl_data), 32'hA1);
    send(9'h1A2); send(9'h100); send(9'h100);
    check_val("t2_cd4", 32'(bus.ctrl_data), 32'h00);
    send(9'h000);
    check_val("t2_lend", 32'(bus.line_end), 32'd0);
    check_val("t2_unlock", 32'(bus.sync_locked), 32'd0);
    idle(1);
    check_val("t2_nctrl", 32'(cnt_ctrl - b_ctrl), 32'd4);
    check_val("t2_npix",  32'(cnt_pix - b_pix), 32'd0);
    check_val("t2_sbhold", 32'(bus.status_byte), 32'h5A);

    // Corrupted header (06 for 05), then a good header and a 1-pixel line
    snap();
    begin
      logic [8:0] bh [12];
      bh = '{9'h10A, 9'h101, 9'h102, 9'h103, 9'h104, 9'h106,
             9'h10A, 9'h101, 9'h102, 9'h103, 9'h104, 9'h1CC};
      for (int i = 0; i < 12; i++) send(bh[i]);
    end
    check_val("t3_nolock", 32'(bus.sync_locked), 32'd0);
    send(9'h1FF); send(9'h1FF); send(9'h177); send(9'h000);
    idle(1);
    check_val("t3_noerr", 32'((cnt_esync - b_esync) + (cnt_elen - b_elen)), 32'd0);
    check_val("t3_noout", 32'((cnt_pix - b_pix) + (cnt_lend - b_lend)), 32'd0);
    send_hdr();
    send(9'h1FF); send(9'h1FF); send(9'h177); send(9'h000);
    check_val("t3_llen", 32'(bus.line_len), 32'd1);
    check_val("t3_lcnt", 32'(bus.line_count), 32'd1);
    check_val("t3_pd", 32'(last_pix), 32'h77);

    // Mismatch on a 10A word restarts at hdr_idx=1; then a zero-length line
    send(9'h10A); send(9'h101); send(9'h102); send(9'h10A);
    begin
      logic [8:0] rh [11];
      rh = '{9'h101, 9'h102, 9'h103, 9'h104, 9'h105,
             9'h10A, 9'h101, 9'h102, 9'h103, 9'h104, 9'h1CC};
      for (int i = 0; i < 11; i++) send(rh[i]);
    end
    check_val("t3_relock", 32'(bus.sync_locked), 32'd1);
    send(9'h1FF); send(9'h1FF); send(9'h000);
    check_val("t3_zlend", 32'(bus.line_end), 32'd1);
    check_val("t3_zllen", 32'(bus.line_len), 32'd0);
    check_val("t3_zlcnt", 32'(bus.line_count), 32'd2);

    // Bad second type word
    send_hdr();
    send(9'h1FF); send(9'h1EE);
    check_val("t4_esync", 32'(bus.err_sync), 32'd1);
    check_val("t4_unlock", 32'(bus.sync_locked), 32'd0);

    // Overlong data packet with in_valid gaps
    gap = 1'b1;
    snap();
    send_hdr();
    send(9'h1FF); send(9'h1FF);
    for (int i = 0; i < 1024; i++) send({1'b1, 8'(i)});
    idle(2);
    check_val("t5_npix", 32'(cnt_pix - b_pix), 32'd1023);
    check_val("t5_elen", 32'(cnt_elen - b_elen), 32'd1);
    check_val("t5_nlend", 32'(cnt_lend - b_lend), 32'd0);
    check_val("t5_lastpix", 32'(last_pix), 32'hFE);
    check_val("t5_unlock", 32'(bus.sync_locked), 32'd0);
    send_hdr();
    send(9'h1FF); send(9'h1FF); send(9'h1AB); send(9'h000);
    idle(1);
    check_val("t5_llen", 32'(bus.line_len), 32'd1);
    check_val("t5_lcnt", 32'(bus.line_count), 32'd3);
    check_val("t5_pd", 32'(last_pix), 32'hAB);
    gap = 1'b0;

    // Reset after 5 pixels
    snap();
    send_hdr();
    send(9'h1FF); send(9'h1FF);
    for (int i = 0; i < 5; i++) send(9'h140 + 9'(i));
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check_val("t6_pv",   32'(bus.pix_valid), 32'd0);
    check_val("t6_pd",   32'(bus.pix_data), 32'd0);
    check_val("t6_lock", 32'(bus.sync_locked), 32'd0);
    check_val("t6_lcnt", 32'(bus.line_count), 32'd0);
    check_val("t6_lend", 32'(bus.line_end), 32'd0);
    send(9'h000);
    idle(1);
    check_val("t6_nolend", 32'((cnt_lend - b_lend) + (cnt_elen - b_elen) + (cnt_esync - b_esync)), 32'd0);
    send_hdr();
    send(9'h1FF); send(9'h1FF); send(9'h155); send(9'h166); send(9'h000);
    check_val("t6_llen", 32'(bus.line_len), 32'd2);
    check_val("t6_lcnt2", 32'(bus.line_count), 32'd1);

    // Terminator words are ignored while waiting for the type
    send_hdr();
    send(9'h000); send(9'h0FF);
    check_val("t7_locked", 32'(bus.sync_locked), 32'd1);
    send(9'h1FF); send(9'h1FF); send(9'h199); send(9'h000);
    check_val("t7_llen", 32'(bus.line_len), 32'd1);
    check_val("t7_lcnt", 32'(bus.line_count), 32'd2);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
